// File: rtl/ifu_pkg.sv
// Shared types and constants for the RV32I instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } ifu_state_t;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of {pc,instr} entries with a single-cycle flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [63:0]   wdata,
    input  logic          pop,
    output logic [63:0]   rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory, queues returned words with their PCs and hands them to
// the decoder over valid/ready. Redirects flush the queue and drop any
// response still in flight.
// Build option: define IFU_MISALIGN_CHECK_EN to fault on misaligned redirect
// targets; otherwise the target's low two bits are ignored.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction_code,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    ifu_state_t  state, state_d;
    logic [31:0] pc, pc_d;
    logic        fault_d;
    logic        req_pend;
    logic        push;
    logic        req_fire;
    logic        outstanding;
    logic        room;
    logic        stale_pending;
    logic        misalign;
    logic [31:0] redirect_tgt;

    logic [63:0]   fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misalign     = (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
`else
    assign misalign     = 1'b0;
    assign redirect_tgt = {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};
`endif

    // A request counts against queue space until its response lands.
    assign outstanding = (state == WAIT) || (state == FLUSH);
    assign room        = !fifo_full && ((fifo_count + CW'(outstanding)) < DEPTH_C);

    // Once raised, a request stays up until accepted even if en drops.
    assign imem_req_valid = rst_n && (state == REQ) &&
                            (req_pend || (en && !fetch_fault && room));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is still owed to us after this cycle: a redirect must drop it.
    assign stale_pending = ((state == REQ) && req_fire) ||
                           (((state == WAIT) || (state == FLUSH)) && !imem_rsp_valid);

    assign inst_valid       = !fifo_empty;
    assign instruction_code = fifo_empty ? 32'h0 : fifo_rdata[31:0];
    assign inst_pc          = fifo_empty ? 32'h0 : fifo_rdata[63:32];

    // State, PC, sticky fault and request-hold registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= REQ;
            pc          <= RESET_PC;
            fetch_fault <= 1'b0;
            req_pend    <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            fetch_fault <= fault_d;
            req_pend    <= imem_req_valid && !imem_req_ready && !redirect_valid;
        end
    end

    // Next-state, PC update and queue push; redirect overrides everything.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        fault_d = fetch_fault;
        push    = 1'b0;
        case (state)
            REQ: begin
                if (req_fire) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        push    = 1'b1;
                        pc_d    = pc + PC_STEP;
                        state_d = REQ;
                    end
                end
            end
            FLUSH: begin
                if (imem_rsp_valid) state_d = REQ;
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = REQ;
        endcase
        if (redirect_valid) begin
            push    = 1'b0;
            pc_d    = redirect_tgt;
            fault_d = misalign;
            if (stale_pending)  state_d = FLUSH;
            else if (misalign)  state_d = HALT;
            else                state_d = REQ;
        end
    end

    ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({pc, imem_rsp_data}),
        .pop   (inst_valid && inst_ready),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
